// File: rtl/slow_clock_monitor.sv
// ---------------------------------------------------------------------------
// slow_clock_monitor
//
// Watches a slow, asynchronous clock (SLOW_IN) from the fast system clock
// CLK_IN. It produces one-cycle pulses for each rising and falling edge of
// SLOW_IN. It measures the slow period in CLK_IN cycles. It reports LOCKED
// once consecutive periods agree within TOL. It reports LOST when no rising
// edge arrives within TIMEOUT cycles.
//
// Parameters
//   TIMEOUT      CLK_IN cycles without a rising SLOW_IN edge before LOST
//                (legal range 2 .. 2^28-1)
//   TOL          largest difference between consecutive periods that still
//                counts as agreement for lock
//
// Ports
//   CLK_IN       fast system clock, all logic on its rising edge
//   RST_N        asynchronous active-low reset
//   SLOW_IN      slow clock, asynchronous to CLK_IN
//   TICK         one-cycle pulse per SLOW_IN rising edge
//   FALL_TICK    one-cycle pulse per SLOW_IN falling edge
//   PERIOD       CLK_IN cycles between the last two rising-edge detections
//   PERIOD_VALID PERIOD holds a valid measurement
//   LOCKED       consecutive periods agree within TOL
//   LOST         no rising edge within TIMEOUT cycles
// ---------------------------------------------------------------------------
module slow_clock_monitor #(
    parameter logic [27:0] TIMEOUT = 28'd62500000,
    parameter logic [27:0] TOL     = 28'd2
) (
    input  logic        CLK_IN,
    input  logic        RST_N,
    input  logic        SLOW_IN,
    output logic        TICK,
    output logic        FALL_TICK,
    output logic [27:0] PERIOD,
    output logic        PERIOD_VALID,
    output logic        LOCKED,
    output logic        LOST
);

    localparam int CNT_W = 28;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_LOST    = 2'd3
    } state_t;

    // Unsigned distance between two counts. Subtracting the smaller from
    // the larger keeps the result inside 28 bits with no wrap.
    function automatic logic [CNT_W-1:0] abs_diff(input logic [CNT_W-1:0] a,
                                                  input logic [CNT_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    // Saturating increment, so the counter can never wrap.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : (v + CNT_W'(1));
    endfunction

    // Synchronizer, edge history and edge pulses
    logic             s1;
    logic             s2;
    logic             s3;
    logic [1:0]       prime;
    logic             armed;
    logic             rise;
    logic             fall;

    // Measurement state
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] period_nxt;
    logic             period_valid_nxt;
    logic             in_tol;
    logic             timeout_hit;

    // ---- stage: synchronizer s1 -> s2, history s3 ----
    // The detector is armed only after the synchronizer has seen SLOW_IN
    // low. Until then, the zeros loaded by reset do not reflect a real
    // level. This stops a SLOW_IN that is already high at reset release
    // from producing a false rising edge.
    // prime records that s2 holds a real sample. s2 does so from the
    // second clock edge after reset onwards.
    always_ff @(posedge CLK_IN or negedge RST_N) begin
        if (!RST_N) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            s3    <= 1'b0;
            prime <= 2'b00;
            armed <= 1'b0;
        end else begin
            s1    <= SLOW_IN;
            s2    <= s1;
            s3    <= s2;
            prime <= {prime[0], 1'b1};
            armed <= armed | (prime[1] & ~s2);
        end
    end

    assign rise = s2 & ~s3 & armed;
    assign fall = ~s2 & s3;

    // ---- stage: registered edge pulses ----
    always_ff @(posedge CLK_IN or negedge RST_N) begin
        if (!RST_N) begin
            TICK      <= 1'b0;
            FALL_TICK <= 1'b0;
        end else begin
            TICK      <= rise;
            FALL_TICK <= fall;
        end
    end

    // The new period is CNT+1. CNT never exceeds TIMEOUT-1 while
    // measuring, so the sum always fits in 28 bits.
    assign cnt_inc     = sat_inc(cnt);
    assign in_tol      = (abs_diff(cnt_inc, PERIOD) <= TOL);
    assign timeout_hit = (cnt == (TIMEOUT - CNT_W'(1)));

    // Next-state, counter and period decode. A rise always takes
    // priority over the timeout, so a rise that lands in the last counted
    // cycle is measured normally.
    always_comb begin
        state_nxt        = state;
        cnt_nxt          = cnt;
        period_nxt       = PERIOD;
        period_valid_nxt = PERIOD_VALID;

        case (state)
            ST_IDLE: begin
                cnt_nxt = '0;
                if (rise) begin
                    state_nxt = ST_MEASURE;
                end
            end

            ST_MEASURE: begin
                cnt_nxt = cnt_inc;
                if (rise) begin
                    cnt_nxt          = '0;
                    period_nxt       = cnt_inc;
                    period_valid_nxt = 1'b1;
                    if (PERIOD_VALID && in_tol) begin
                        state_nxt = ST_LOCKED;
                    end
                end else if (timeout_hit) begin
                    state_nxt        = ST_LOST;
                    period_nxt       = '0;
                    period_valid_nxt = 1'b0;
                end
            end

            ST_LOCKED: begin
                cnt_nxt = cnt_inc;
                if (rise) begin
                    cnt_nxt          = '0;
                    period_nxt       = cnt_inc;
                    period_valid_nxt = 1'b1;
                    if (!in_tol) begin
                        state_nxt = ST_MEASURE;
                    end
                end else if (timeout_hit) begin
                    state_nxt        = ST_LOST;
                    period_nxt       = '0;
                    period_valid_nxt = 1'b0;
                end
            end

            ST_LOST: begin
                // The first edge after a loss only restarts the count. No
                // period is latched, because the gap before it is not a
                // real period.
                if (rise) begin
                    cnt_nxt   = '0;
                    state_nxt = ST_MEASURE;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // ---- stage: state, counter and measurement registers ----
    always_ff @(posedge CLK_IN or negedge RST_N) begin
        if (!RST_N) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            PERIOD       <= '0;
            PERIOD_VALID <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            PERIOD       <= period_nxt;
            PERIOD_VALID <= period_valid_nxt;
        end
    end

    assign LOCKED = (state == ST_LOCKED);
    assign LOST   = (state == ST_LOST);

endmodule

// File: tb/tb_slow_clock_monitor.sv
module tb_slow_clock_monitor;

    localparam int TO = 20;
    localparam int TL = 1;
    localparam int CP = 10;

    localparam int S_IDLE = 0;
    localparam int S_MEAS = 1;
    localparam int S_LOCK = 2;
    localparam int S_LOST = 3;

    logic        CLK_IN  = 1'b0;
    logic        RST_N   = 1'b0;
    logic        SLOW_IN = 1'b0;
    logic        TICK;
    logic        FALL_TICK;
    logic [27:0] PERIOD;
    logic        PERIOD_VALID;
    logic        LOCKED;
    logic        LOST;

    slow_clock_monitor #(
        .TIMEOUT(28'd20),
        .TOL    (28'd1)
    ) dut (
        .CLK_IN      (CLK_IN),
        .RST_N       (RST_N),
        .SLOW_IN     (SLOW_IN),
        .TICK        (TICK),
        .FALL_TICK   (FALL_TICK),
        .PERIOD      (PERIOD),
        .PERIOD_VALID(PERIOD_VALID),
        .LOCKED      (LOCKED),
        .LOST        (LOST)
    );

    always #5 CLK_IN = ~CLK_IN;

    typedef struct {
        logic [27:0] period;
        logic        valid;
        logic        locked;
        logic        lost;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;

    // Expectation model, advanced once per rising edge driven on SLOW_IN.
    int   m_state  = S_IDLE;
    int   m_period = 0;
    bit   m_valid  = 1'b0;
    time  last_t   = 0;
    bit   have_last = 1'b0;

    always @(posedge CLK_IN) cyc++;

    task automatic model_reset();
        m_state   = S_IDLE;
        m_period  = 0;
        m_valid   = 1'b0;
        have_last = 1'b0;
        exp_q.delete();
    endtask

    // Called at the moment a rising edge is driven. The gap to the previous
    // driven rise is the period the monitor must see. A gap longer than
    // TIMEOUT means the monitor has already declared the clock lost.
    task automatic push_rise();
        int   g;
        int   d;
        exp_t e;
        g = int'(($time - last_t) / CP);
        if (have_last && (m_state == S_MEAS || m_state == S_LOCK) && g > TO) begin
            m_state  = S_LOST;
            m_period = 0;
            m_valid  = 1'b0;
        end
        d = (g > m_period) ? (g - m_period) : (m_period - g);
        case (m_state)
            S_MEAS: begin
                if (m_valid && d <= TL) m_state = S_LOCK;
                m_period = g;
                m_valid  = 1'b1;
            end
            S_LOCK: begin
                if (d > TL) m_state = S_MEAS;
                m_period = g;
            end
            default: m_state = S_MEAS;
        endcase
        e.period = 28'(m_period);
        e.valid  = m_valid;
        e.locked = (m_state == S_LOCK);
        e.lost   = 1'b0;
        exp_q.push_back(e);
        last_t    = $time;
        have_last = 1'b1;
    endtask

    // Scoreboard: every TICK pops one expectation and checks the outputs.
    always @(negedge CLK_IN) begin
        exp_t e;
        if (RST_N === 1'b1 && TICK === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_tick cycle=%0d got TICK=1 want no tick", cyc);
            end else begin
                e = exp_q.pop_front();
                if (PERIOD !== e.period) begin
                    miscompares++;
                    $display("FAIL sb_period cycle=%0d got %0d want %0d", cyc, PERIOD, e.period);
                end
                vectors++;
                if (PERIOD_VALID !== e.valid) begin
                    miscompares++;
                    $display("FAIL sb_valid cycle=%0d got %0b want %0b", cyc, PERIOD_VALID, e.valid);
                end
                vectors++;
                if (LOCKED !== e.locked) begin
                    miscompares++;
                    $display("FAIL sb_locked cycle=%0d got %0b want %0b", cyc, LOCKED, e.locked);
                end
                vectors++;
                if (LOST !== e.lost) begin
                    miscompares++;
                    $display("FAIL sb_lost cycle=%0d got %0b want %0b", cyc, LOST, e.lost);
                end
            end
        end
    end

    // n rising edges spaced p cycles apart, high for half the period.
    task automatic drive_period(input int p, input int n);
        int h;
        h = p / 2;
        for (int i = 0; i < n; i++) begin
            @(negedge CLK_IN);
            SLOW_IN = 1'b1;
            push_rise();
            repeat (h) @(negedge CLK_IN);
            SLOW_IN = 1'b0;
            repeat (p - h - 1) @(negedge CLK_IN);
        end
    endtask

    task automatic test_reset();
        RST_N   = 1'b0;
        SLOW_IN = 1'b0;
        repeat (3) @(negedge CLK_IN);
        vectors++;
        if ({TICK, FALL_TICK, PERIOD_VALID, LOCKED, LOST} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_flags got %b want 00000",
                     {TICK, FALL_TICK, PERIOD_VALID, LOCKED, LOST});
        end
        vectors++;
        if (PERIOD !== 28'd0) begin
            miscompares++;
            $display("FAIL reset_period got %0d want 0", PERIOD);
        end
        RST_N = 1'b1;
        model_reset();
        repeat (TO + 10) @(negedge CLK_IN);
        vectors++;
        if ({LOCKED, LOST} !== 2'b00) begin
            miscompares++;
            $display("FAIL idle_no_timeout got LOCKED,LOST=%b want 00", {LOCKED, LOST});
        end
    endtask

    task automatic test_latency();
        logic want;
        @(negedge CLK_IN);
        SLOW_IN = 1'b1;
        push_rise();
        for (int e = 0; e < 4; e++) begin
            @(negedge CLK_IN);
            want = (e == 2);
            vectors++;
            if (TICK !== want) begin
                miscompares++;
                $display("FAIL tick_latency after_edge=%0d got %0b want %0b", e, TICK, want);
            end
        end
        SLOW_IN = 1'b0;
        for (int e = 0; e < 4; e++) begin
            @(negedge CLK_IN);
            want = (e == 2);
            vectors++;
            if (FALL_TICK !== want) begin
                miscompares++;
                $display("FAIL fall_latency after_edge=%0d got %0b want %0b", e, FALL_TICK, want);
            end
        end
        repeat (TO + 10) @(negedge CLK_IN);
    endtask

    task automatic test_lock();
        drive_period(10, 2);
        vectors++;
        if ({PERIOD, PERIOD_VALID, LOCKED} !== {28'd10, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL lock_second_tick got P=%0d V=%0b L=%0b want P=10 V=1 L=0",
                     PERIOD, PERIOD_VALID, LOCKED);
        end
        drive_period(10, 1);
        vectors++;
        if ({PERIOD, LOCKED} !== {28'd10, 1'b1}) begin
            miscompares++;
            $display("FAIL lock_third_tick got P=%0d L=%0b want P=10 L=1", PERIOD, LOCKED);
        end
    endtask

    task automatic test_period_jump();
        drive_period(14, 2);
        vectors++;
        if ({PERIOD, LOCKED} !== {28'd14, 1'b0}) begin
            miscompares++;
            $display("FAIL jump_unlock got P=%0d L=%0b want P=14 L=0", PERIOD, LOCKED);
        end
        drive_period(14, 1);
        vectors++;
        if ({PERIOD, LOCKED} !== {28'd14, 1'b1}) begin
            miscompares++;
            $display("FAIL jump_relock got P=%0d L=%0b want P=14 L=1", PERIOD, LOCKED);
        end
    endtask

    task automatic test_loss_recovery();
        int t_tick;
        int t_lost;
        t_tick = -1;
        t_lost = -1;
        @(negedge CLK_IN);
        SLOW_IN = 1'b1;
        push_rise();
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK_IN);
            if (TICK === 1'b1) begin
                t_tick = cyc;
                break;
            end
        end
        repeat (4) @(negedge CLK_IN);
        SLOW_IN = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge CLK_IN);
            if (LOST === 1'b1) begin
                t_lost = cyc;
                break;
            end
        end
        vectors++;
        if (t_tick < 0 || t_lost < 0 || (t_lost - t_tick) != TO) begin
            miscompares++;
            $display("FAIL lost_delay got tick=%0d lost=%0d want lost-tick=%0d",
                     t_tick, t_lost, TO);
        end
        vectors++;
        if ({PERIOD, PERIOD_VALID, LOCKED} !== {28'd0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL lost_outputs got P=%0d V=%0b L=%0b want 0 0 0",
                     PERIOD, PERIOD_VALID, LOCKED);
        end
        drive_period(10, 1);
        vectors++;
        if ({PERIOD, PERIOD_VALID, LOCKED, LOST} !== {28'd0, 1'b0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL recover_first got P=%0d V=%0b L=%0b X=%0b want 0 0 0 0",
                     PERIOD, PERIOD_VALID, LOCKED, LOST);
        end
        drive_period(10, 1);
        vectors++;
        if ({PERIOD, PERIOD_VALID} !== {28'd10, 1'b1}) begin
            miscompares++;
            $display("FAIL recover_second got P=%0d V=%0b want P=10 V=1", PERIOD, PERIOD_VALID);
        end
    endtask

    task automatic test_coincidence();
        int lost_seen;
        lost_seen = 0;
        repeat (TO + 10) @(negedge CLK_IN);
        drive_period(20, 1);
        fork
            drive_period(20, 3);
            begin
                repeat (60) begin
                    @(negedge CLK_IN);
                    if (LOST === 1'b1) lost_seen++;
                end
            end
        join
        vectors++;
        if (lost_seen != 0) begin
            miscompares++;
            $display("FAIL coincide_lost got %0d lost cycles want 0", lost_seen);
        end
        vectors++;
        if ({PERIOD, LOCKED} !== {28'd20, 1'b1}) begin
            miscompares++;
            $display("FAIL coincide_period got P=%0d L=%0b want P=20 L=1", PERIOD, LOCKED);
        end
    endtask

    task automatic test_async_reset();
        int ticks;
        ticks = 0;
        @(negedge CLK_IN);
        SLOW_IN = 1'b1;
        push_rise();
        repeat (5) @(negedge CLK_IN);
        vectors++;
        if (LOCKED !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_reset_locked got %0b want 1", LOCKED);
        end
        @(posedge CLK_IN);
        #2;
        RST_N = 1'b0;
        model_reset();
        #1;
        vectors++;
        if ({TICK, FALL_TICK, PERIOD_VALID, LOCKED, LOST} !== 5'b0) begin
            miscompares++;
            $display("FAIL async_flags got %b want 00000",
                     {TICK, FALL_TICK, PERIOD_VALID, LOCKED, LOST});
        end
        vectors++;
        if (PERIOD !== 28'd0) begin
            miscompares++;
            $display("FAIL async_period got %0d want 0", PERIOD);
        end
        #4;
        RST_N = 1'b1;
        repeat (15) begin
            @(negedge CLK_IN);
            if (TICK === 1'b1) ticks++;
        end
        vectors++;
        if (ticks != 0) begin
            miscompares++;
            $display("FAIL high_at_release got %0d ticks want 0", ticks);
        end
        SLOW_IN = 1'b0;
        repeat (6) @(negedge CLK_IN);
        drive_period(10, 3);
        vectors++;
        if ({PERIOD, PERIOD_VALID, LOCKED} !== {28'd10, 1'b1, 1'b1}) begin
            miscompares++;
            $display("FAIL after_reset_lock got P=%0d V=%0b L=%0b want 10 1 1",
                     PERIOD, PERIOD_VALID, LOCKED);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_latency();
        test_lock();
        test_period_jump();
        test_loss_recovery();
        test_coincidence();
        test_async_reset();
        repeat (5) @(negedge CLK_IN);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL missing_ticks got %0d unmatched want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
